// File: rtl/memc_pkg.sv
// Shared constants for the memc_* memory controller port model.
package memc_pkg;

    // Command encodings on memc_cmd_instr.
    localparam logic [2:0] MEMC_CMD_WR = 3'b000;
    localparam logic [2:0] MEMC_CMD_RD = 3'b001;

    // Width of the byte address presented on memc_cmd_addr.
    localparam int MEMC_ADDR_W = 28;

    // Bit positions inside the sticky err_flags vector.
    localparam int ERR_WR_NO_DATA = 0;  // write command issued with the write-data FIFO empty
    localparam int ERR_WR_OVF     = 1;  // write-data push while the FIFO is full
    localparam int ERR_RD_UNDF    = 2;  // read-data pop while the read FIFO is empty
    localparam int ERR_BAD_INSTR  = 3;  // accepted command with an illegal encoding

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO: the head entry is always visible
// on pop_data, and pop advances to the next entry on the clock edge.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8            // power of 2, at least 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));
    assign count = cnt;

    // A pop frees a slot on the same edge, so a push into a full FIFO is
    // still taken when it coincides with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Empty reads as zero so the output is clean while nothing is queued.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    // NOTE: every register in a clocked block is assigned with <= so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
            else if (do_pop && !do_push) cnt <= cnt - CNT_W'(1);
        end
    end

    // Entry storage.
    // NOTE: the data array has no reset; validity is tracked by the pointers,
    // which keeps the array mappable onto RAM primitives.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/memc_mem_model.sv
// Parametrised model of the memc_* external memory port: byte-masked word
// storage, write-data FIFO, fixed-latency read pipe into a read-return FIFO,
// periodic cmd_full throttling and sticky protocol-error flags.
module memc_mem_model
    import memc_pkg::*;
#(
    parameter int DATA_W          = 256,
    parameter int ADDR_W          = 10,
    parameter int ADDR_LSB        = 3,
    parameter int RD_LAT          = 4,
    parameter int RDQ_DEPTH       = 8,
    parameter int WDQ_DEPTH       = 8,
    parameter int THROTTLE_PERIOD = 8
) (
    input  logic                    eclk,
    input  logic                    rst,
    input  logic                    memc_cmd_en,
    input  logic [2:0]              memc_cmd_instr,
    input  logic [MEMC_ADDR_W-1:0]  memc_cmd_addr,
    output logic                    memc_cmd_full,
    input  logic                    memc_wr_en,
    input  logic [DATA_W-1:0]       memc_wr_data,
    input  logic [DATA_W/8-1:0]     memc_wr_mask,
    output logic                    memc_wr_full,
    input  logic                    memc_rd_en,
    output logic [DATA_W-1:0]       memc_rd_data,
    output logic                    memc_rd_empty,
    output logic [3:0]              err_flags,
    output logic [15:0]             cmd_drop_cnt
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WDQ_W  = DATA_W + STRB_W;
    localparam int OCC_W  = $clog2(RDQ_DEPTH) + 1;
    localparam int THR_W  = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;

    logic [DATA_W-1:0]           mem [2**ADDR_W];
    logic [ADDR_W-1:0]           cmd_idx;
    logic                        cmd_full_q;
    logic                        cmd_acc, wr_acc, rd_acc, bad_acc;
    logic                        do_write, rdq_pop;
    logic [WDQ_W-1:0]            wdq_head;
    logic                        wdq_empty;
    logic [$clog2(WDQ_DEPTH):0]  wdq_count_unused;
    logic                        rdq_full_unused;
    logic [$clog2(RDQ_DEPTH):0]  rdq_count_unused;
    logic                        unused_addr;
    logic [RD_LAT-1:0]           pipe_vld;
    logic [DATA_W-1:0]           pipe_data [RD_LAT];
    logic [OCC_W-1:0]            occ, occ_next;
    logic [THR_W-1:0]            thr, thr_next;
    logic                        cmd_full_next;

    // Address bits outside the index field alias onto the same word.
    assign cmd_idx     = memc_cmd_addr[ADDR_LSB +: ADDR_W];
    assign unused_addr = ^memc_cmd_addr;

    assign memc_cmd_full = cmd_full_q;
    assign cmd_acc  = memc_cmd_en & ~cmd_full_q;
    assign wr_acc   = cmd_acc & (memc_cmd_instr == MEMC_CMD_WR);
    assign rd_acc   = cmd_acc & (memc_cmd_instr == MEMC_CMD_RD);
    assign bad_acc  = cmd_acc & (memc_cmd_instr != MEMC_CMD_WR) & (memc_cmd_instr != MEMC_CMD_RD);
    assign do_write = wr_acc & ~wdq_empty;
    assign rdq_pop  = memc_rd_en & ~memc_rd_empty;

    // Write-data FIFO entries carry {data, mask}; a write command pops one.
    sync_fifo_fwft #(.WIDTH(WDQ_W), .DEPTH(WDQ_DEPTH)) u_wdq (
        .clk       (eclk),
        .rst       (rst),
        .push      (memc_wr_en),
        .push_data ({memc_wr_data, memc_wr_mask}),
        .pop       (wr_acc),
        .pop_data  (wdq_head),
        .full      (memc_wr_full),
        .empty     (wdq_empty),
        .count     (wdq_count_unused)
    );

    // Read-return FIFO fed by the tail of the latency pipe.
    sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(RDQ_DEPTH)) u_rdq (
        .clk       (eclk),
        .rst       (rst),
        .push      (pipe_vld[RD_LAT-1]),
        .push_data (pipe_data[RD_LAT-1]),
        .pop       (memc_rd_en),
        .pop_data  (memc_rd_data),
        .full      (rdq_full_unused),
        .empty     (memc_rd_empty),
        .count     (rdq_count_unused)
    );

    // Byte-masked storage write, storage read capture and the read data pipe.
    // Stage 0 is the storage output register; stages 1..RD_LAT-1 add latency.
    always_ff @(posedge eclk) begin
        if (do_write) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (!wdq_head[b]) mem[cmd_idx][b*8 +: 8] <= wdq_head[STRB_W + b*8 +: 8];
            end
        end
        if (rd_acc) pipe_data[0] <= mem[cmd_idx];
        for (int i = 1; i < RD_LAT; i++) pipe_data[i] <= pipe_data[i-1];
    end

    // Read pipe valid bits; cleared by reset so in-flight reads are discarded.
    always_ff @(posedge eclk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rd_acc;
            for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    // Next throttle phase and next outstanding-read count (pipe + RDQ).
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        thr_next = '0;
        if (THROTTLE_PERIOD > 1 && thr != THR_W'(THROTTLE_PERIOD - 1)) thr_next = thr + THR_W'(1);
        occ_next = occ + OCC_W'(rd_acc) - OCC_W'(rdq_pop);
        cmd_full_next = ((THROTTLE_PERIOD != 0) && (thr_next == '0)) ||
                        (occ_next >= OCC_W'(RDQ_DEPTH));
    end

    // Control state: throttle phase, occupancy, registered cmd_full, errors, drops.
    always_ff @(posedge eclk or posedge rst) begin
        if (rst) begin
            thr          <= '0;
            occ          <= '0;
            cmd_full_q   <= 1'b1;
            err_flags    <= '0;
            cmd_drop_cnt <= '0;
        end else begin
            thr        <= thr_next;
            occ        <= occ_next;
            cmd_full_q <= cmd_full_next;
            if (wr_acc && wdq_empty)                   err_flags[ERR_WR_NO_DATA] <= 1'b1;
            if (memc_wr_en && memc_wr_full && !wr_acc) err_flags[ERR_WR_OVF]     <= 1'b1;
            if (memc_rd_en && memc_rd_empty)           err_flags[ERR_RD_UNDF]    <= 1'b1;
            if (bad_acc)                               err_flags[ERR_BAD_INSTR]  <= 1'b1;
            if (memc_cmd_en && cmd_full_q && cmd_drop_cnt != 16'hFFFF)
                cmd_drop_cnt <= cmd_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_memc_mem_model.sv
// Self-checking bench for memc_mem_model: a word/byte-mask storage model and
// a write-data queue model predict read returns, which are queued when a read
// is accepted and compared when the DUT pops them.
module tb_memc_mem_model;
    import memc_pkg::*;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  mask;
    } wdq_ent_t;

    logic         tb_clk = 1'b0;
    logic         rst;
    logic         memc_cmd_en;
    logic [2:0]   memc_cmd_instr;
    logic [27:0]  memc_cmd_addr;
    logic         memc_cmd_full;
    logic         memc_wr_en;
    logic [255:0] memc_wr_data;
    logic [31:0]  memc_wr_mask;
    logic         memc_wr_full;
    logic         memc_rd_en;
    logic [255:0] memc_rd_data;
    logic         memc_rd_empty;
    logic [3:0]   err_flags;
    logic [15:0]  cmd_drop_cnt;

    logic [255:0] model_mem [1024];
    logic [255:0] sb_q [$];
    wdq_ent_t     wdq_m [$];
    logic [15:0]  drop_m;
    int           n_checks = 0;
    int           n_fail   = 0;

    localparam logic [255:0] PAT_A5  = {32{8'hA5}};
    localparam logic [255:0] PAT_D1  = {16{16'h1234}};
    localparam logic [255:0] PAT_D2  = {16{16'hBEEF}};
    localparam logic [255:0] PAT_ONE = {256{1'b1}};

    memc_mem_model dut (
        .eclk           (tb_clk),
        .rst            (rst),
        .memc_cmd_en    (memc_cmd_en),
        .memc_cmd_instr (memc_cmd_instr),
        .memc_cmd_addr  (memc_cmd_addr),
        .memc_cmd_full  (memc_cmd_full),
        .memc_wr_en     (memc_wr_en),
        .memc_wr_data   (memc_wr_data),
        .memc_wr_mask   (memc_wr_mask),
        .memc_wr_full   (memc_wr_full),
        .memc_rd_en     (memc_rd_en),
        .memc_rd_data   (memc_rd_data),
        .memc_rd_empty  (memc_rd_empty),
        .err_flags      (err_flags),
        .cmd_drop_cnt   (cmd_drop_cnt)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Predict the effect of the current cycle's inputs, then advance one clock.
    task automatic tick();
        bit       acc;
        bit       wpop;
        int       idx;
        wdq_ent_t e;
        acc  = memc_cmd_en && !memc_cmd_full;
        idx  = int'(memc_cmd_addr[12:3]);
        wpop = 1'b0;
        if (memc_cmd_en && memc_cmd_full && drop_m != 16'hFFFF) drop_m++;
        if (memc_rd_en && !memc_rd_empty) begin
            if (sb_q.size() == 0) check("rdq_spurious", 256'(memc_rd_empty), 256'd1);
            else                  check("rd_data", memc_rd_data, sb_q.pop_front());
        end
        if (acc && memc_cmd_instr == MEMC_CMD_WR && wdq_m.size() != 0) begin
            e = wdq_m.pop_front();
            wpop = 1'b1;
            for (int b = 0; b < 32; b++)
                if (!e.mask[b]) model_mem[idx][b*8 +: 8] = e.data[b*8 +: 8];
        end
        if (acc && memc_cmd_instr == MEMC_CMD_RD) sb_q.push_back(model_mem[idx]);
        if (memc_wr_en && (wdq_m.size() < 8 || wpop)) begin
            e.data = memc_wr_data;
            e.mask = memc_wr_mask;
            wdq_m.push_back(e);
        end
        @(posedge tb_clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] instr, input logic [27:0] addr);
        int n = 0;
        while (memc_cmd_full && n < 32) begin
            tick();
            n++;
        end
        if (memc_cmd_full) check("issue_timeout", 256'(memc_cmd_full), 256'd0);
        memc_cmd_en    = 1'b1;
        memc_cmd_instr = instr;
        memc_cmd_addr  = addr;
        tick();
        memc_cmd_en = 1'b0;
    endtask

    task automatic push_wr(input logic [255:0] data, input logic [31:0] mask);
        memc_wr_en   = 1'b1;
        memc_wr_data = data;
        memc_wr_mask = mask;
        tick();
        memc_wr_en = 1'b0;
    endtask

    // Pop until every predicted read has been returned, never popping empty.
    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 64) begin
            memc_rd_en = !memc_rd_empty;
            tick();
            n++;
        end
        memc_rd_en = 1'b0;
        check("drain_left", 256'(sb_q.size()), 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1;
        memc_cmd_en = 1'b0; memc_cmd_instr = 3'd0; memc_cmd_addr = '0;
        memc_wr_en = 1'b0; memc_wr_data = '0; memc_wr_mask = '0; memc_rd_en = 1'b0;
        drop_m = '0;
        repeat (3) @(posedge tb_clk);
        #1;
        check("rst_cmd_full", 256'(memc_cmd_full), 256'd1);
        check("rst_wr_full",  256'(memc_wr_full),  256'd0);
        check("rst_rd_empty", 256'(memc_rd_empty), 256'd1);
        check("rst_rd_data",  memc_rd_data,        256'd0);
        check("rst_err",      256'(err_flags),     256'd0);
        check("rst_drop",     256'(cmd_drop_cnt),  256'd0);
        rst = 1'b0;

        // Basic write then read, with read latency measured from the accept edge.
        push_wr(PAT_A5, 32'h0);
        issue(MEMC_CMD_WR, 28'h40);
        issue(MEMC_CMD_RD, 28'h40);
        lat = 0;
        while (memc_rd_empty && lat < 20) begin
            tick();
            lat++;
        end
        check("rd_latency", 256'(lat), 256'd4);
        drain();
        check("err_after_basic", 256'(err_flags), 256'd0);

        // Byte masking: low 16 bytes protected, upper 16 bytes written.
        push_wr(256'd0, 32'h0);
        issue(MEMC_CMD_WR, 28'h0);
        push_wr(PAT_ONE, 32'h0000FFFF);
        issue(MEMC_CMD_WR, 28'h0);
        issue(MEMC_CMD_RD, 28'h0);
        drain();
        // Aliased address (bit above the index field) maps to the same word.
        issue(MEMC_CMD_RD, 28'h0000_2000 | 28'h40);
        drain();

        // Read of X accepted in the same cycle as a new data push; the write
        // of that data lands a cycle later and must not affect the read.
        push_wr(PAT_D1, 32'h0);
        issue(MEMC_CMD_WR, 28'h80);
        while (memc_cmd_full) tick();
        memc_cmd_en = 1'b1; memc_cmd_instr = MEMC_CMD_RD; memc_cmd_addr = 28'h80;
        memc_wr_en = 1'b1; memc_wr_data = PAT_D2; memc_wr_mask = 32'h0;
        tick();
        memc_cmd_en = 1'b0; memc_wr_en = 1'b0;
        issue(MEMC_CMD_WR, 28'h80);
        issue(MEMC_CMD_RD, 28'h80);
        drain();

        // Protocol errors accumulate sticky bits.
        issue(MEMC_CMD_WR, 28'h40);
        check("err_wr_no_data", 256'(err_flags), 256'h1);
        issue(MEMC_CMD_RD, 28'h40);
        drain();
        memc_rd_en = 1'b1;
        tick();
        memc_rd_en = 1'b0;
        check("err_rd_empty", 256'(err_flags), 256'h5);
        issue(3'b010, 28'h40);
        check("err_bad_instr", 256'(err_flags), 256'hD);
        for (int i = 0; i < 8; i++) push_wr(PAT_D1 ^ 256'(i), 32'h0);
        check("wdq_full", 256'(memc_wr_full), 256'd1);
        push_wr(PAT_D2, 32'h0);
        check("err_wr_ovf", 256'(err_flags), 256'hF);

        // 64 cycles of back-to-back reads while draining: only throttle refusals.
        memc_cmd_en = 1'b1; memc_cmd_instr = MEMC_CMD_RD; memc_cmd_addr = 28'h40;
        for (int i = 0; i < 64; i++) begin
            memc_rd_en = !memc_rd_empty;
            tick();
        end
        memc_cmd_en = 1'b0;
        check("throttle_drops", 256'(cmd_drop_cnt), 256'd8);
        drain();

        // No draining: outstanding reads cap at the RDQ depth.
        memc_cmd_en = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("outstanding_cap", 256'(sb_q.size()), 256'd8);
        check("cap_cmd_full", 256'(memc_cmd_full), 256'd1);
        check("cap_rd_empty", 256'(memc_rd_empty), 256'd0);
        memc_cmd_en = 1'b0;
        check("drop_count", 256'(cmd_drop_cnt), 256'(drop_m));
        drain();

        // Reset with reads in flight.
        issue(MEMC_CMD_RD, 28'h40);
        issue(MEMC_CMD_RD, 28'h80);
        issue(MEMC_CMD_RD, 28'h0);
        rst = 1'b1;
        #1;
        check("mid_rst_cmd_full", 256'(memc_cmd_full), 256'd1);
        check("mid_rst_rd_empty", 256'(memc_rd_empty), 256'd1);
        check("mid_rst_rd_data",  memc_rd_data,        256'd0);
        check("mid_rst_wr_full",  256'(memc_wr_full),  256'd0);
        check("mid_rst_err",      256'(err_flags),     256'd0);
        check("mid_rst_drop",     256'(cmd_drop_cnt),  256'd0);
        sb_q.delete();
        wdq_m.delete();
        drop_m = '0;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("post_rst_cmd_full", 256'(memc_cmd_full), 256'((i % 8) == 0));
            check("post_rst_rd_empty", 256'(memc_rd_empty), 256'd1);
            tick();
        end
        check("post_rst_err", 256'(err_flags), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
